outport_uart_tx: RTL and testbench
==================================

# outport_uart_tx

Serial transmitter that consumes the processor's 16-bit output port. Each output-port load strobe queues the current port word in a small FIFO. Each queued word is sent over a standard 8N1 UART line as two bytes: low byte first, LSB first within each byte. The block sits directly downstream of the core's OutPort/OUTLD path and lets software stream values off-chip without stalling.

## Interface
- CLKS_PER_BIT, 16, clock cycles per UART bit; integer ≥ 2.
- DEPTH, 4, FIFO depth in 16-bit words; power of 2, ≥ 2.
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one sampled-high edge fully reinitialises the block.
- OutPort  in  16  word to queue, sampled when OutLoad is high.
- OutLoad  in  1  push strobe, one word per cycle it is sampled high.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high when the FSM is not IDLE or fifo_count ≠ 0.
- fifo_count  out  $clog2(DEPTH)+1  number of words currently queued.
- overflow  out  1  sticky; set when a push is dropped; cleared only by reset.

## Operation
- FIFO: circular buffer with read and write pointers and an occupancy count.
  - Full means count == DEPTH, evaluated before the edge.
  - A push while full is dropped and sets overflow. This holds even if a pop occurs on the same edge.
  - Push and pop on the same edge when not full: count is unchanged and the data stays in order.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If count ≠ 0, pop the head word into a 16-bit shift register, clear the byte select (low byte) and go to START. Popping and entering START happen on the same edge.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = the current byte's bit[index] for CLKS_PER_BIT cycles each. After index 7, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. Then:
    - if the low byte was just sent, set byte select to high and go to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1;
  - reloads to 0 on every bit boundary and on entry to START;
  - does not run in IDLE.
- tx is driven from a register, so there are no combinational glitches.
- Widths:
  - bit index is 3 bits;
  - baud counter is $clog2(CLKS_PER_BIT) bits;
  - pointers wrap modulo DEPTH with natural binary rollover.
- OutPort is captured as-is; no change detection.

## Timing
- Reset values: tx = 1, busy = 0, fifo_count = 0, overflow = 0, FSM = IDLE, pointers and counters = 0. FIFO contents are don't-care.
- Reset in mid-frame returns tx to 1 on the reset edge and discards all queued words. The next frame starts with a full start bit.
- Latency: a push captured at edge E into an empty FIFO gives tx = 0 starting at edge E+1.
- Frame length: 10·CLKS_PER_BIT cycles per byte; 20·CLKS_PER_BIT cycles per word.
- Back-to-back words: the high-byte stop bit lasts CLKS_PER_BIT cycles, followed by exactly 1 IDLE cycle with tx = 1. The next start bit follows, so there are CLKS_PER_BIT+1 high cycles in total.
- busy:
  - rises on the edge after a push into an idle, empty block;
  - falls on the edge that returns the FSM to IDLE with count == 0.
- overflow rises on the edge of the dropped push.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and DEPTH = 4.
- Reset: hold reset 2 cycles with OutLoad toggling → tx = 1, busy = 0, fifo_count = 0, overflow = 0; no start bit while reset is high.
- Single word: push 0xA55A → tx falls one edge later, then shows 4-cycle bits in this order:
  - 0, then 0,1,0,1,1,0,1,0, then 1 (byte 0x5A);
  - 0, then 1,0,1,0,0,1,0,1, then 1 (byte 0xA5).
  
  busy drops 80 cycles after tx first falls.
- Burst: push 0x0001..0x0006 on 6 consecutive edges while idle → fifo_count goes 1,1,2,3,4. The 6th push is dropped and overflow = 1. Words 0x0001..0x0005 are transmitted in order; 0x0006 never appears.
- Gap: queue 0x00FF and 0xFF00 → between the first word's high-byte stop bit and the second word's start bit, tx is high exactly 5 cycles.
- Full with simultaneous pop: fill to 4 while transmitting, then push on the edge where IDLE pops → push dropped, overflow = 1, fifo_count = 3.
- Reset mid-frame: assert reset during bit 3 of the low byte of 0x1234 with 2 words queued → tx = 1 on the next edge, fifo_count = 0, busy = 0. A fresh push of 0x00AA then transmits a complete, correct frame.

Source files
------------

// File: rtl/outport_uart_tx.sv
// ============================================================================
// Module   : outport_uart_tx
// Purpose  : Queues 16-bit output-port words in a small FIFO and sends each
//            one as two 8N1 UART bytes (low byte first, LSB first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              OutPort,
    input  logic                     OutLoad,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]    c_FULL      = (c_PTR_W + 1)'(DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [15:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_overflow;

    logic [1:0]          r_state;
    logic [15:0]         r_shift;
    logic                r_byte_sel;
    logic [2:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_baud;
    logic                r_tx;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_baud_done;
    logic [7:0]          w_cur_byte;
    logic [2:0]          w_bit_idx_inc;

    logic [1:0]          w_state_nxt;
    logic [15:0]         w_shift_nxt;
    logic                w_byte_sel_nxt;
    logic [2:0]          w_bit_idx_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic                w_tx_nxt;

    // Fullness is judged before the edge, so a pop on the same edge cannot rescue a push.
    assign w_full        = (r_count == c_FULL);
    assign w_push        = OutLoad && !w_full;
    assign w_pop         = (r_state == c_S_IDLE) && (r_count != '0);
    assign w_baud_done   = (r_baud == c_BAUD_LAST);
    assign w_cur_byte    = r_byte_sel ? r_shift[15:8] : r_shift[7:0];
    assign w_bit_idx_inc = r_bit_idx + 3'd1;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= OutPort;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
            if (OutLoad && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Next tx value is computed alongside the next state so the line is purely registered.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_byte_sel_nxt = r_byte_sel;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_nxt     = r_baud;
        w_tx_nxt       = r_tx;
        case (r_state)
            c_S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                if (r_count != '0) begin
                    w_state_nxt    = c_S_START;
                    w_shift_nxt    = r_mem[r_rd_ptr];
                    w_byte_sel_nxt = 1'b0;
                    w_tx_nxt       = 1'b0;
                end
            end
            c_S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_done) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = c_S_DATA;
                    w_tx_nxt      = w_cur_byte[0];
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            c_S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_tx_nxt      = w_cur_byte[w_bit_idx_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            c_S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!r_byte_sel) begin
                        w_byte_sel_nxt = 1'b1;
                        w_state_nxt    = c_S_START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_shift    <= '0;
            r_byte_sel <= 1'b0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_sel <= w_byte_sel_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_baud     <= w_baud_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != c_S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_outport_uart_tx.sv
// ============================================================================
// Module   : tb_outport_uart_tx
// Purpose  : Self-checking bench for outport_uart_tx with a line decoder and a
//            timeline model of FIFO occupancy, busy and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_outport_uart_tx;

    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 20 * C;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        OutLoad = 1'b0;
    logic [15:0] OutPort = 16'h0000;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    outport_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .OutPort    (OutPort),
        .OutLoad    (OutLoad),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Line decoder: samples each bit mid-period on the falling clock edge.
    int          mon_cnt = -1;
    logic [9:0]  mon_bits;
    logic [7:0]  rx_q[$];
    int          rx_ferr = 0;

    always @(negedge clock) begin
        if (mon_cnt < 0 && tx === 1'b0) mon_cnt = 0;
        if (mon_cnt >= 0) begin
            if (mon_cnt % C == C / 2) mon_bits[mon_cnt / C] = tx;
            mon_cnt++;
            if (mon_cnt == 10 * C) begin
                if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) rx_ferr++;
                rx_q.push_back(mon_bits[8:1]);
                mon_cnt = -1;
            end
        end
        if (reset) mon_cnt = -1;
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [15:0] w);
        OutPort = w;
        OutLoad = 1'b1;
        step();
        OutLoad = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rx_q.delete();
        rx_ferr = 0;
    endtask

    // Expected per-cycle line level for one word: two 10-symbol bytes, C cycles per symbol.
    function automatic logic [FRAME-1:0] frame_bits(input logic [15:0] w);
        logic [FRAME-1:0] f;
        logic [9:0]       sym;
        int               p;
        f = '0;
        p = 0;
        for (int b = 0; b < 2; b++) begin
            sym = {1'b1, w[b*8 +: 8], 1'b0};
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < C; c++) begin
                    f[p] = sym[k];
                    p++;
                end
            end
        end
        return f;
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        OutLoad = 1'b1;
        OutPort = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({tx, busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got tx=%b busy=%b cnt=%0d ovf=%b, want tx=1 busy=0 cnt=0 ovf=0",
                         i, tx, busy, fifo_count, overflow);
            end
            OutLoad = ~OutLoad;
        end
        reset   = 1'b0;
        OutLoad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({tx, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_after[%0d]: got tx=%b busy=%b, want tx=1 busy=0", i, tx, busy);
            end
        end
    endtask

    task automatic test_single_word();
        logic [FRAME-1:0] cap;
        push(16'hA55A);
        n_cmp++;
        if ({tx, busy, fifo_count} !== {1'b1, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL single_push: got tx=%b busy=%b cnt=%0d, want tx=1 busy=1 cnt=1", tx, busy, fifo_count);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            cap[i] = tx;
            if (i == 0) begin
                n_cmp++;
                if (fifo_count !== 3'd0) begin
                    n_fail++;
                    $display("FAIL single_pop: got cnt=%0d, want 0", fifo_count);
                end
            end
            if (i == FRAME - 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy_late: got busy=%b, want 1", busy);
                end
            end
        end
        n_cmp++;
        if (cap !== frame_bits(16'hA55A)) begin
            n_fail++;
            $display("FAIL single_frame: got %h, want %h", cap, frame_bits(16'hA55A));
        end
        step();
        n_cmp++;
        if ({tx, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_done: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_burst();
        int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
        int k;
        do_reset();
        OutLoad = 1'b1;
        for (int i = 0; i < 6; i++) begin
            OutPort = 16'(i + 1);
            step();
            n_cmp++;
            if ({fifo_count, overflow} !== {3'(exp_cnt[i]), (i == 5)}) begin
                n_fail++;
                $display("FAIL burst_push[%0d]: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                         i, fifo_count, overflow, exp_cnt[i], (i == 5));
            end
        end
        OutLoad = 1'b0;
        k = 0;
        while (busy && k < 1000) begin
            step();
            k++;
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || rx_q.size() != 10 || rx_ferr != 0) begin
            n_fail++;
            $display("FAIL burst_drain: got busy=%b bytes=%0d ferr=%0d, want busy=0 bytes=10 ferr=0",
                     busy, rx_q.size(), rx_ferr);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (rx_q[i] !== ((i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00)) begin
                    n_fail++;
                    $display("FAIL burst_byte[%0d]: got %h, want %h", i, rx_q[i],
                             ((i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00));
                end
            end
        end
    endtask

    task automatic test_gap();
        logic [2*FRAME:0] cap;
        int run;
        do_reset();
        push(16'h00FF);
        push(16'hFF00);
        cap[0] = tx;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            step();
            cap[i] = tx;
        end
        n_cmp++;
        if (cap[FRAME-1:0] !== frame_bits(16'h00FF)) begin
            n_fail++;
            $display("FAIL gap_frame1: got %h, want %h", cap[FRAME-1:0], frame_bits(16'h00FF));
        end
        n_cmp++;
        if (cap[2*FRAME:FRAME+1] !== frame_bits(16'hFF00)) begin
            n_fail++;
            $display("FAIL gap_frame2: got %h, want %h", cap[2*FRAME:FRAME+1], frame_bits(16'hFF00));
        end
        run = 0;
        for (int j = FRAME; j >= 0; j--) begin
            if (cap[j] !== 1'b1) break;
            run++;
        end
        n_cmp++;
        if (run != C + 1) begin
            n_fail++;
            $display("FAIL gap_high_run: got %0d cycles, want %0d", run, C + 1);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_done: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] words[5] = '{16'h1357, 16'h2468, 16'hBEEF, 16'h0F0F, 16'h7E81};
        int k;
        do_reset();
        for (int i = 0; i < 5; i++) push(words[i]);
        n_cmp++;
        if (fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_fill: got cnt=%0d, want 4", fifo_count);
        end
        for (int i = 0; i < FRAME - 3; i++) step();
        n_cmp++;
        if ({tx, fifo_count, overflow} !== {1'b1, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pre_pop: got tx=%b cnt=%0d ovf=%b, want tx=1 cnt=4 ovf=0", tx, fifo_count, overflow);
        end
        OutPort = 16'hDEAD;
        OutLoad = 1'b1;
        step();
        OutLoad = 1'b0;
        n_cmp++;
        if ({tx, fifo_count, overflow} !== {1'b0, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL full_pop_push: got tx=%b cnt=%0d ovf=%b, want tx=0 cnt=3 ovf=1", tx, fifo_count, overflow);
        end
        k = 0;
        while (busy && k < 1000) begin
            step();
            k++;
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || rx_q.size() != 10 || rx_ferr != 0) begin
            n_fail++;
            $display("FAIL full_drain: got busy=%b bytes=%0d ferr=%0d, want busy=0 bytes=10 ferr=0",
                     busy, rx_q.size(), rx_ferr);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if ({rx_q[2*i+1], rx_q[2*i]} !== words[i]) begin
                    n_fail++;
                    $display("FAIL full_word[%0d]: got %h, want %h", i, {rx_q[2*i+1], rx_q[2*i]}, words[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [FRAME-1:0] cap;
        do_reset();
        push(16'h1234);
        push(16'h5678);
        push(16'h9ABC);
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if ({tx, fifo_count} !== {1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL midreset_pre: got tx=%b cnt=%0d, want tx=0 cnt=2", tx, fifo_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({tx, fifo_count, busy} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_post: got tx=%b cnt=%0d busy=%b, want tx=1 cnt=0 busy=0", tx, fifo_count, busy);
        end
        push(16'h00AA);
        for (int i = 0; i < FRAME; i++) begin
            step();
            cap[i] = tx;
        end
        n_cmp++;
        if (cap !== frame_bits(16'h00AA)) begin
            n_fail++;
            $display("FAIL midreset_frame: got %h, want %h", cap, frame_bits(16'h00AA));
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_done: got busy=%b, want 0", busy);
        end
    endtask

    // Timeline model: a popped word occupies the line for FRAME cycles, then one idle cycle.
    task automatic test_random();
        logic [15:0] mq[$];
        logic [15:0] sent[$];
        logic        m_ovf;
        logic        m_busy;
        logic        m_full;
        logic        ld;
        logic [15:0] d;
        int          m_txend;
        int          m_free;
        bit          done;
        do_reset();
        m_ovf   = 1'b0;
        m_txend = cyc;
        m_free  = cyc;
        done    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ld = (i < 1500) && ($urandom_range(99) < 3);
            d  = 16'($urandom);
            OutLoad = ld;
            OutPort = d;
            step();
            m_full = (mq.size() == D);
            if (mq.size() != 0 && cyc >= m_free) begin
                sent.push_back(mq.pop_front());
                m_txend = cyc + FRAME;
                m_free  = m_txend + 1;
            end
            if (ld) begin
                if (m_full) m_ovf = 1'b1;
                else        mq.push_back(d);
            end
            m_busy = (mq.size() != 0) || (cyc < m_txend);
            n_cmp++;
            if ({busy, overflow, fifo_count} !== {m_busy, m_ovf, 3'(mq.size())}) begin
                n_fail++;
                $display("FAIL random_state@%0d: got busy=%b ovf=%b cnt=%0d, want busy=%b ovf=%b cnt=%0d",
                         cyc, busy, overflow, fifo_count, m_busy, m_ovf, mq.size());
            end
            if (i >= 1500 && mq.size() == 0 && cyc > m_txend + 2) begin
                done = 1'b1;
                break;
            end
        end
        OutLoad = 1'b0;
        n_cmp++;
        if (!done || rx_q.size() != 2 * sent.size() || rx_ferr != 0) begin
            n_fail++;
            $display("FAIL random_drain: got done=%b bytes=%0d ferr=%0d, want done=1 bytes=%0d ferr=0",
                     done, rx_q.size(), rx_ferr, 2 * sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                n_cmp++;
                if ({rx_q[2*i+1], rx_q[2*i]} !== sent[i]) begin
                    n_fail++;
                    $display("FAIL random_word[%0d]: got %h, want %h", i, {rx_q[2*i+1], rx_q[2*i]}, sent[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_gap();
        test_full_pop();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
